// File: rtl/calc_method_select.sv
// calc_method_select: debounced front-panel selector for the calculation-method code
module calc_method_select_db #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic stable_q, stable_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // accept a new level only after it has persisted for DEBOUNCE_CYCLES clocks
  always_comb begin
    cnt_d = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CMAX) stable_d = sync_q[1];
      else cnt_d = cnt_q + 1'b1;
    end
  end
  // synchronizer, debounce state and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      stable_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      prev_q <= stable_q;
      cnt_q <= cnt_d;
    end
  end
  assign press_o = stable_q & ~prev_q;
endmodule

module calc_method_select #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_METHODS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_confirm,
  input  logic       clear,
  output logic [2:0] method_sel,
  output logic       method_valid,
  output logic       method_locked
);
  typedef enum logic {SELECT, LOCKED} state_t;
  localparam logic [2:0] LAST = 3'(NUM_METHODS - 1);
  state_t state_q, state_d;
  logic [2:0] sel_q, sel_d, inc, dec;
  logic valid_q, valid_d;
  logic nx, pv, cf;
  calc_method_select_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .rst_n(rst_n), .btn_i(btn_next), .press_o(nx));
  calc_method_select_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .press_o(pv));
  calc_method_select_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_conf (.clk(clk), .rst_n(rst_n), .btn_i(btn_confirm), .press_o(cf));
  assign inc = (sel_q == LAST) ? 3'd0 : sel_q + 3'd1;
  assign dec = (sel_q == 3'd0) ? LAST : sel_q - 3'd1;
  // confirm beats stepping; presses in LOCKED (even alongside clear) are dropped
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    valid_d = 1'b0;
    if (state_q == SELECT) begin
      if (cf) begin
        valid_d = 1'b1;
        state_d = LOCKED;
      end else if (nx ^ pv) sel_d = nx ? inc : dec;
    end else if (clear) state_d = SELECT;
  end
  // selection state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SELECT;
      sel_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      valid_q <= valid_d;
    end
  end
  assign method_sel = sel_q;
  assign method_valid = valid_q;
  assign method_locked = (state_q == LOCKED);
endmodule

// File: doc/calc_method_select.md
# calc_method_select

Front-panel input controller that produces the calculation-method code consumed by the method display and the calculator core. It synchronizes and debounces three push-buttons (next, prev, confirm) and steps a 3-bit method code through 0..4 (0:T, 1:A, 2:B, 3:C, 4:J) with wrap-around. On confirm it issues a one-cycle `method_valid` pulse and locks the selection until the core sends `clear`.

## Interface

**Parameters**
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive clock cycles a synchronized button level must persist before it is accepted (10 ms at 100 MHz). Legal range is >= 2.
- `NUM_METHODS`, default 5: number of method codes. The valid range is 0..NUM_METHODS-1, and NUM_METHODS must be <= 8.

**Ports**
- `clk`, input, 1 bit: system clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `btn_next`, input, 1 bit: raw, asynchronous, active-high button that advances the method.
- `btn_prev`, input, 1 bit: raw, asynchronous, active-high button that steps the method back.
- `btn_confirm`, input, 1 bit: raw, asynchronous, active-high button that confirms and locks the selection.
- `clear`, input, 1 bit: synchronous single-cycle pulse from the core that unlocks the selection.
- `method_sel`, output, 3 bits: current method code, registered.
- `method_valid`, output, 1 bit: one-cycle pulse, registered, marking a confirmed selection.
- `method_locked`, output, 1 bit: level, registered; high while the state machine is in LOCKED.

## Operation

**Input conditioning (one identical channel per button)**
- The raw input passes through a 2-flop synchronizer to give `sync`.
- Each channel holds a `stable` level and a counter of width `$clog2(DEBOUNCE_CYCLES)`.
- If `sync == stable`, the counter clears.
- If `sync != stable` and the counter is below DEBOUNCE_CYCLES-1, the counter increments.
- If `sync != stable` and the counter equals DEBOUNCE_CYCLES-1, `stable` takes the value of `sync` and the counter clears.
- `press = stable & ~stable_d`. This is a one-cycle pulse on an accepted rising level.
- Releases are debounced the same way but generate no event.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

**State machine (states SELECT and LOCKED)**

*SELECT*
- Priority order: confirm > (next XOR prev).
- Confirm press: `method_valid` <= 1 for one cycle, `method_locked` <= 1, go to LOCKED. `method_sel` is unchanged, even if next or prev are pressed in the same cycle.
- Next press only: `method_sel` <= `method_sel` + 1. NUM_METHODS-1 wraps to 0.
- Prev press only: `method_sel` <= `method_sel` - 1. 0 wraps to NUM_METHODS-1.
- Next and prev pressed in the same cycle: ignored, no change.
- `clear` is ignored in SELECT.

*LOCKED*
- Next, prev and confirm presses are ignored. The debounce channels keep running, so no stale press fires after unlock.
- `clear` = 1: go to SELECT, `method_locked` <= 0. `method_sel` is retained.
- A press pulse that arrives in the same cycle as `clear` is discarded.

**Reset**
- `rst_n` low at any time, including mid-debounce or while LOCKED, forces immediately:
  - all synchronizer flops, `stable`, `stable_d` and counters to 0;
  - state to SELECT;
  - `method_sel` = 0, `method_valid` = 0, `method_locked` = 0.
- A button still held when reset releases is accepted as one press after the debounce interval.

## Timing

- Raw button rises and is held before edge 1:
  - sync = 1 after edge 2;
  - `stable` = 1 after edge 2+DEBOUNCE_CYCLES;
  - `press` is high during the following cycle;
  - `method_sel`, `method_valid` and `method_locked` update at edge 3+DEBOUNCE_CYCLES.
- Overall latency from raw edge to output is 3+DEBOUNCE_CYCLES clocks, with up to one clock of uncertainty from asynchronous sampling.
- `method_valid` is high for exactly 1 cycle per accepted confirm.
- `method_locked` rises on the same edge that `method_valid` rises.
- `clear` is sampled on the edge after it asserts; `method_locked` is low from that edge.
- A held button generates exactly one press. A new press requires a debounced release followed by a debounced rise.
- Minimum spacing between accepted presses on one button is 2×DEBOUNCE_CYCLES.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4 and NUM_METHODS=5.

1. **Reset and basic latency:** after reset, check `method_sel`=0, `method_valid`=0, `method_locked`=0. Raise btn_next before edge 1 and hold it → `method_sel`=1 exactly at edge 7, and no further change while held.
2. **Wrap-around:** 5 separate next presses from 0 → sequence 1,2,3,4,0. Then one prev press from 0 → 4.
3. **Debounce:** 3-cycle pulses on btn_next, and bounce toggling every 2 cycles for 20 cycles → `method_sel` unchanged. The subsequent clean hold → exactly +1.
4. **Confirm and lock:** select 3, then confirm → `method_valid` high for 1 cycle, `method_locked`=1, `method_sel`=3. Next and prev presses while locked → no change. `clear` pulse → `method_locked`=0 and `method_sel` still 3. A following next press → 4.
5. **Simultaneous events:** next and prev rise together → no change. Confirm and next rise together at `method_sel`=2 → valid pulse, `method_sel`=2, locked. `clear` coincident with a press pulse → unlock only.
6. **Reset mid-operation:** assert `rst_n` low while LOCKED with `method_sel`=4 and a debounce in progress → all outputs 0 asynchronously. After release, the still-held button yields exactly one press at the debounce latency.
